seq_divider: RTL and testbench

- Parametrised multi-cycle radix-2 restoring divider for the execute stage's multiply/divide unit.
- Implements all four RISC-V M-extension divide ops: DIV, DIVU, REM and REMU.
- Produces RISC-V-defined results for divide-by-zero and signed overflow.
- Uses a start/busy/done handshake with a cancel input, so the pipeline can kill an in-flight division on flush.

---
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider.sv | 149 ++++++++++++++
 tb/tb_seq_divider.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake bundle between the execute-stage mul/div unit and the sequential divider.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while busy is low, cancel kills an in-flight op.
//   master: drives start/op/a/b/cancel, receives result/busy/done
//   slave : the divider itself
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;      // 00 DIV, 01 DIVU, 10 REM, 11 REMU
    logic [WIDTH-1:0] a;       // dividend
    logic [WIDTH-1:0] b;       // divisor
    logic             cancel;
    logic [WIDTH-1:0] result;  // quotient or remainder, held until the next done
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, cancel,
        input  result, busy, done
    );

    modport slave (
        input  start, op, a, b, cancel,
        output result, busy, done
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with RISC-V divide-by-zero and overflow results.
// Latency: WIDTH+1 cycles start->done for normal ops, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: start ignored while busy (no queueing); cancel while busy returns to idle with no done.
//   clk_i, rst_i (async, active-high); div_if.slave carries start/op/a/b/cancel in, result/busy/done out.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    seq_divider_if.slave  div_if
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifts out MSB-first while quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [WIDTH:0]   rem_q, rem_d;       // partial remainder, one bit wider than the divisor
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             special_q, special_d; // quo_q already holds the final answer
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic             is_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_shift;
    logic             ge;
    logic [WIDTH-1:0] sel;
    logic             neg;
    logic [WIDTH-1:0] fixed;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            special_q <= special_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        special_d = special_q;
        result_d  = result_q;
        done_d    = 1'b0;

        // op[0]==0 selects the signed variants (DIV, REM)
        is_signed = ~div_if.op[0];
        a_neg     = is_signed & div_if.a[WIDTH-1];
        b_neg     = is_signed & div_if.b[WIDTH-1];
        // Negating the most negative value wraps to itself, which read unsigned is the right magnitude
        a_mag     = a_neg ? -div_if.a : div_if.a;
        b_mag     = b_neg ? -div_if.b : div_if.b;

        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        ge        = (rem_shift >= {1'b0, dvs_q});

        sel       = op_q[1] ? rem_q[WIDTH-1:0] : quo_q;
        neg       = op_q[1] ? rneg_q : qneg_q;
        fixed     = special_q ? quo_q : (neg ? -sel : sel);

        unique case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    op_d      = div_if.op;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    qneg_d    = a_neg ^ b_neg;
                    rneg_d    = a_neg;
                    special_d = 1'b0;
                    state_d   = CALC;
                    if (div_if.b == '0) begin
                        special_d = 1'b1;
                        quo_d     = div_if.op[1] ? div_if.a : '1;
                        state_d   = FIX;
                    end else if (is_signed && div_if.a == {1'b1, {(WIDTH-1){1'b0}}}
                                 && div_if.b == '1) begin
                        special_d = 1'b1;
                        quo_d     = div_if.op[1] ? '0 : div_if.a;
                        state_d   = FIX;
                    end
                end
            end
            CALC: begin
                if (div_if.cancel) begin
                    state_d = IDLE;
                end else begin
                    rem_d = ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
                    quo_d = {quo_q[WIDTH-2:0], ge};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!div_if.cancel) begin
                    result_d = fixed;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign div_if.result = result_q;
    assign div_if.busy   = (state_q != IDLE);
    assign div_if.done   = done_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   done_cnt;
    logic [W-1:0] last_exp;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];

    seq_divider_if #(.WIDTH(W)) dif ();

    seq_divider #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, with the RISC-V special cases stated explicitly
    function automatic logic [W-1:0] ref_div(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        if (y == 0) return o[1] ? x : {W{1'b1}};
        if (!o[0]) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'(x);
            sy = longint'(y);
        end
        q = sx / sy;   // truncates toward zero; overflow case gives 2^31 which wraps correctly
        r = sx % sy;   // sign of dividend
        return o[1] ? r[W-1:0] : q[W-1:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        if (y == 0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    task automatic push_exp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.res = ref_div(o, x, y);
        e.cyc = cyc + 1 + ref_lat(o, x, y);
        sb_q.push_back(e);
        last_exp = e.res;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        @(negedge clk);
        dif.start = 1'b1;
        dif.op    = o;
        dif.a     = x;
        dif.b     = y;
        if (push) push_exp(o, x, y);
        @(negedge clk);
        dif.start = 1'b0;
        dif.op    = 2'($urandom_range(0, 3));
        dif.a     = $urandom;
        dif.b     = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (dif.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", W'(dif.busy), '0);
    endtask

    // Monitor: every done pulse pops one expectation and checks value, arrival cycle and busy
    always @(negedge clk) begin
        if (!rst && dif.done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("result", dif.result, e.res);
                check("done_cycle", W'(cyc), W'(e.cyc));
                check("busy_with_done", W'(dif.busy), '0);
            end
        end
    end

    logic [1:0]   d_op[11] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11};
    logic [W-1:0] d_a[11]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] d_b[11]  = '{32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd9};

    initial begin
        int           snap;
        logic [1:0]   o;
        logic [W-1:0] x, y;

        n_cmp = 0; n_bad = 0; done_cnt = 0; cyc = 0; last_exp = '0;
        rst = 1'b1;
        dif.start = 1'b0; dif.cancel = 1'b0; dif.op = '0; dif.a = '0; dif.b = '0;
        #1;
        check("rst_result", dif.result, '0);
        check("rst_busy", W'(dif.busy), '0);
        check("rst_done", W'(dif.done), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed: signed basics, divide-by-zero, overflow, unsigned max
        for (int i = 0; i < 11; i++) begin
            issue(d_op[i], d_a[i], d_b[i], 1'b1);
            wait_idle();
        end

        // start held high: second op accepted in the done cycle, first result holds meanwhile
        @(negedge clk);
        dif.start = 1'b1; dif.op = 2'b01; dif.a = 32'hFFFF_FFFF; dif.b = 32'd2;
        push_exp(2'b01, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        dif.op = 2'b10; dif.a = $urandom; dif.b = $urandom;
        wait_idle();
        dif.op = 2'b00; dif.a = 32'hFFFF_FF9C; dif.b = 32'd7;
        push_exp(2'b00, 32'hFFFF_FF9C, 32'd7);
        @(negedge clk);
        dif.start = 1'b0; dif.a = $urandom; dif.b = $urandom;
        check("b2b_busy", W'(dif.busy), 1);
        repeat (10) @(negedge clk);
        check("b2b_hold", dif.result, 32'h7FFF_FFFF);
        wait_idle();

        // Mid-cycle reset pulse with no clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("pulse_result", dif.result, '0);
        check("pulse_busy", W'(dif.busy), '0);
        check("pulse_done", W'(dif.done), '0);
        #1 rst = 1'b0;
        last_exp = '0;

        // Cancel at CALC cycle 5: no done, result keeps the previous value
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        issue(2'b01, $urandom, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        dif.cancel = 1'b1;
        dif.start  = 1'b1;
        @(negedge clk);
        dif.cancel = 1'b0;
        dif.start  = 1'b0;
        check("cancel_busy", W'(dif.busy), '0);
        snap = done_cnt;
        repeat (40) @(negedge clk);
        check("cancel_no_done", W'(done_cnt), W'(snap));
        check("cancel_result", dif.result, last_exp);
        issue(2'b00, 32'd100, 32'd7, 1'b1);
        wait_idle();

        // Reset across edge 10 of a DIVU: op lost, no done
        issue(2'b01, $urandom, $urandom | 32'd1, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst10_busy", W'(dif.busy), '0);
        rst = 1'b0;
        snap = done_cnt;
        repeat (40) @(negedge clk);
        check("rst10_no_done", W'(done_cnt), W'(snap));
        check("rst10_result", dif.result, '0);

        // Randomised ops with operands biased toward corner values
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 6))
                0: y = '0;
                1: y = '1;
                2: y = W'($urandom_range(1, 15));
                3: begin x = 32'h8000_0000; y = '1; end
                4: begin x = W'($urandom_range(0, 50)); y = -W'($urandom_range(1, 9)); end
                default: y = $urandom;
            endcase
            issue(o, x, y, 1'b1);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", W'(sb_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
